// File: rtl/fan_i2c_pkg.sv
// Shared definitions for the fan controller I2C target: register map, reset
// values and the target FSM state encoding.
package fan_i2c_pkg;

  localparam logic [7:0] REG_SPEED_SET  = 8'h00;
  localparam logic [7:0] REG_CONFIG     = 8'h02;
  localparam logic [7:0] REG_GPIO_DEF   = 8'h04;
  localparam logic [7:0] REG_ALARM_EN   = 8'h08;
  localparam logic [7:0] REG_STATUS     = 8'h0A;
  localparam logic [7:0] REG_TACH0      = 8'h0C;
  localparam logic [7:0] REG_TACH1      = 8'h0E;
  localparam logic [7:0] REG_COUNT_TIME = 8'h16;

  localparam logic [7:0] RST_SPEED_SET  = 8'h00;
  localparam logic [7:0] RST_CONFIG     = 8'h0A;
  localparam logic [7:0] RST_GPIO_DEF   = 8'hFF;
  localparam logic [7:0] RST_ALARM_EN   = 8'h00;
  localparam logic [7:0] RST_COUNT_TIME = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_PTR   = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } fan_state_e;

endpackage

// File: rtl/i2c_fan_target_if.sv
// I2C bus lines seen by the fan target. iSda is the resolved (wired-AND) line;
// the target only ever pulls it low through oSda_oe.
interface i2c_fan_target_if;
  logic iScl;
  logic iSda;
  logic oSda_oe;

  modport slave  (input iScl, input iSda, output oSda_oe);
  modport master (output iScl, output iSda, input oSda_oe);
endinterface

// File: rtl/i2c_line_filter.sv
// Synchronises and de-glitches SCL/SDA, then flags SCL edges and START/STOP
// conditions from the filtered levels.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iScl,
  input  logic iSda,
  output logic oSda,
  output logic oScl_rise,
  output logic oScl_fall,
  output logic oStart,
  output logic oStop
);

  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
  logic                scl_filt_q, sda_filt_q;
  logic                scl_prev_q, sda_prev_q;

  // A level is only accepted once FILT_LEN consecutive samples agree.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], iScl};
      sda_sync_q <= {sda_sync_q[0], iSda};
      scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
      if (&scl_hist_q)       scl_filt_q <= 1'b1;
      else if (~|scl_hist_q) scl_filt_q <= 1'b0;
      if (&sda_hist_q)       sda_filt_q <= 1'b1;
      else if (~|sda_hist_q) sda_filt_q <= 1'b0;
      scl_prev_q <= scl_filt_q;
      sda_prev_q <= sda_filt_q;
    end
  end

  assign oSda      = sda_filt_q;
  assign oScl_rise = scl_filt_q & ~scl_prev_q;
  assign oScl_fall = ~scl_filt_q & scl_prev_q;
  assign oStart    = scl_filt_q & scl_prev_q & sda_prev_q & ~sda_filt_q;
  assign oStop     = scl_filt_q & scl_prev_q & ~sda_prev_q & sda_filt_q;

endmodule

// File: rtl/i2c_fan_target.sv
// I2C target modelling the board fan controller register subset. Never
// stretches SCL; SDA is only pulled low, and only changes on SCL falling edges.
module i2c_fan_target
  import fan_i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         FILT_LEN   = 3
) (
  input  logic                iClk,
  input  logic                iRst,
  i2c_fan_target_if.slave     bus,
  input  logic [7:0]          iTach0,
  input  logic [7:0]          iTach1,
  input  logic [4:0]          iAlarm_Set,
  output logic                oAlert_n,
  output logic [7:0]          oSpeed_Set,
  output logic [7:0]          oConfig,
  output logic [7:0]          oGpio_Def,
  output logic [7:0]          oAlarm_En,
  output logic [7:0]          oCount_Time,
  output logic                oWr_Strobe,
  output logic [7:0]          oWr_Addr,
  output fan_state_e          oDbg_State
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .iClk      (iClk),
    .iRst      (iRst),
    .iScl      (bus.iScl),
    .iSda      (bus.iSda),
    .oSda      (sda),
    .oScl_rise (scl_rise),
    .oScl_fall (scl_fall),
    .oStart    (start),
    .oStop     (stop)
  );

  fan_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] shreg_q, rd_sh_q, ptr_q;
  logic       ack_q, sda_oe_q, wr_strobe_q;
  logic [7:0] wr_addr_q;
  logic [7:0] speed_q, config_q, gpio_q, alarm_en_q, count_q;
  logic [4:0] status_q, stat_cap_q;
  logic [7:0] rd_val, byte_in;

  assign byte_in = {shreg_q[6:0], sda};

  always_comb begin
    rd_val = 8'h00;
    case (ptr_q)
      REG_SPEED_SET:  rd_val = speed_q;
      REG_CONFIG:     rd_val = config_q;
      REG_GPIO_DEF:   rd_val = gpio_q;
      REG_ALARM_EN:   rd_val = alarm_en_q;
      REG_COUNT_TIME: rd_val = count_q;
      REG_STATUS:     rd_val = {3'b000, status_q};
      REG_TACH0:      rd_val = iTach0;
      REG_TACH1:      rd_val = iTach1;
      default:        rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shreg_q     <= 8'h00;
      rd_sh_q     <= 8'h00;
      ptr_q       <= 8'h00;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      speed_q     <= RST_SPEED_SET;
      config_q    <= RST_CONFIG;
      gpio_q      <= RST_GPIO_DEF;
      alarm_en_q  <= RST_ALARM_EN;
      count_q     <= RST_COUNT_TIME;
      status_q    <= 5'd0;
      stat_cap_q  <= 5'd0;
    end else begin
      wr_strobe_q <= 1'b0;
      status_q    <= status_q | iAlarm_Set;
      if (stop) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        ack_q    <= 1'b0;
      end else if (start) begin
        state_q  <= ST_ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
        ack_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_IGNORE: begin
          end
          ST_ADDR: begin
            if (scl_rise) begin
              shreg_q <= byte_in;
              if (cnt_q == 4'd7) begin
                state_q <= ST_ADDR_ACK;
                cnt_q   <= 4'd0;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                if (shreg_q[7:1] == SLAVE_ADDR) begin
                  sda_oe_q <= 1'b1;
                  ack_q    <= 1'b1;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end else if (shreg_q[0]) begin
                // Read: latch the pointed byte and put its MSB on the bus.
                ack_q      <= 1'b0;
                rd_sh_q    <= {rd_val[6:0], 1'b0};
                sda_oe_q   <= ~rd_val[7];
                stat_cap_q <= (ptr_q == REG_STATUS) ? status_q : 5'd0;
                cnt_q      <= 4'd1;
                state_q    <= ST_RD_DATA;
              end else begin
                ack_q    <= 1'b0;
                sda_oe_q <= 1'b0;
                cnt_q    <= 4'd0;
                state_q  <= ST_WR_PTR;
              end
            end
          end
          ST_WR_PTR, ST_WR_DATA: begin
            // cnt_q == 8 marks the ACK slot; rising edges inside it are ignored.
            if (scl_rise && cnt_q != 4'd8) begin
              shreg_q <= byte_in;
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                if (state_q == ST_WR_PTR) begin
                  ptr_q <= byte_in;
                end else begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= ptr_q;
                  case (ptr_q)
                    REG_SPEED_SET:  speed_q    <= byte_in;
                    REG_CONFIG:     config_q   <= byte_in;
                    REG_GPIO_DEF:   gpio_q     <= byte_in;
                    REG_ALARM_EN:   alarm_en_q <= byte_in;
                    REG_COUNT_TIME: count_q    <= byte_in;
                    default: begin
                    end
                  endcase
                end
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (!ack_q) begin
                sda_oe_q <= 1'b1;
                ack_q    <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                ack_q    <= 1'b0;
                cnt_q    <= 4'd0;
                state_q  <= ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                sda_oe_q <= ~rd_sh_q[7];
                rd_sh_q  <= {rd_sh_q[6:0], 1'b0};
                cnt_q    <= cnt_q + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              // Read-to-clear: a set pulse in this same cycle still wins.
              status_q <= (status_q & ~stat_cap_q) | iAlarm_Set;
              if (!sda) ack_q <= 1'b1;
              else      state_q <= ST_IGNORE;
            end else if (scl_fall && ack_q) begin
              ack_q      <= 1'b0;
              rd_sh_q    <= {rd_val[6:0], 1'b0};
              sda_oe_q   <= ~rd_val[7];
              stat_cap_q <= (ptr_q == REG_STATUS) ? status_q : 5'd0;
              cnt_q      <= 4'd1;
              state_q    <= ST_RD_DATA;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.oSda_oe = sda_oe_q;
  assign oAlert_n    = ~|(status_q & alarm_en_q[4:0]);
  assign oSpeed_Set  = speed_q;
  assign oConfig     = config_q;
  assign oGpio_Def   = gpio_q;
  assign oAlarm_En   = alarm_en_q;
  assign oCount_Time = count_q;
  assign oWr_Strobe  = wr_strobe_q;
  assign oWr_Addr    = wr_addr_q;
  assign oDbg_State  = state_q;

endmodule

// File: tb/tb_i2c_fan_target.sv
// Directed bench for i2c_fan_target: an open-drain I2C master model drives
// register writes/reads and the results are compared with hand-computed values.
module tb_i2c_fan_target;
  import fan_i2c_pkg::*;

  localparam int Q = 10;

  logic       clk;
  logic       rst;
  logic       m_scl, m_sda;
  logic [7:0] tach0, tach1;
  logic [4:0] alarm_set;
  logic       alert_n, wr_strobe;
  logic [7:0] speed, cfg, gpio, alarm_en, count_time, wr_addr;
  fan_state_e dbg_state;

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  logic oe_seen = 1'b0;

  i2c_fan_target_if bus ();
  assign bus.iScl = m_scl;
  assign bus.iSda = m_sda & ~bus.oSda_oe;

  i2c_fan_target dut (
    .iClk        (clk),
    .iRst        (rst),
    .bus         (bus),
    .iTach0      (tach0),
    .iTach1      (tach1),
    .iAlarm_Set  (alarm_set),
    .oAlert_n    (alert_n),
    .oSpeed_Set  (speed),
    .oConfig     (cfg),
    .oGpio_Def   (gpio),
    .oAlarm_En   (alarm_en),
    .oCount_Time (count_time),
    .oWr_Strobe  (wr_strobe),
    .oWr_Addr    (wr_addr),
    .oDbg_State  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (bus.oSda_oe) oe_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: one SCL slot = Q low, Q high (sampled mid-high), then SCL low.
  task automatic clk_slot(input logic sda_val, input logic glitch,
                          output logic sda_smp, output logic oe_smp);
    m_sda = sda_val;
    if (glitch) begin
      tick(Q / 2);
      m_scl = 1'b1;
      tick(1);
      m_scl = 1'b0;
      tick(Q / 2 - 1);
    end else begin
      tick(Q);
    end
    m_scl = 1'b1;
    tick(Q / 2);
    sda_smp = bus.iSda;
    oe_smp  = bus.oSda_oe;
    tick(Q / 2);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int nbits, input int glitch_bit);
    logic d, o;
    for (int i = 7; i > 7 - nbits; i--) clk_slot(b[i], (i == glitch_bit), d, o);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack_oe);
    logic d;
    write_bits(b, 8, glitch_bit);
    clk_slot(1'b1, 1'b0, d, ack_oe);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b, output logic ack_oe);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clk_slot(1'b1, 1'b0, s, o);
      b[i] = s;
    end
    clk_slot(ack_bit, 1'b0, s, ack_oe);
  endtask

  task automatic reg_write(input logic [7:0] addr, input logic [7:0] data, output int acks);
    logic a0, a1, a2;
    i2c_start();
    write_byte(8'h90, -1, a0);
    write_byte(addr, -1, a1);
    write_byte(data, -1, a2);
    i2c_stop();
    acks = int'(a0) + int'(a1) + int'(a2);
  endtask

  task automatic reg_read(input logic [7:0] addr, output logic [7:0] data, output logic ack_oe);
    logic a;
    i2c_start();
    write_byte(8'h90, -1, a);
    write_byte(addr, -1, a);
    i2c_start();
    write_byte(8'h91, -1, a);
    read_byte(1'b1, data, ack_oe);
    i2c_stop();
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int acks;
    int s0;
    logic [7:0] rd;
    logic aoe;

    vecs[0] = '{8'h00, 8'h4E, 8'h4E};
    vecs[1] = '{8'h02, 8'h2A, 8'h2A};
    vecs[2] = '{8'h04, 8'hF5, 8'hF5};
    vecs[3] = '{8'h08, 8'h00, 8'h00};
    vecs[4] = '{8'h08, 8'h00, 8'h00};
    vecs[5] = '{8'h08, 8'h00, 8'h00};
    vecs[6] = '{8'h08, 8'h0F, 8'h0F};
    vecs[7] = '{8'h16, 8'h02, 8'h02};
    vecs[8] = '{8'h0C, 8'h33, 8'h64};
    vecs[9] = '{8'h20, 8'h5A, 8'h00};

    rst = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tach0 = 8'h64;
    tach1 = 8'h99;
    alarm_set = 5'd0;
    tick(5);
    rst = 1'b0;
    tick(10);

    check("rst_speed", speed, 8'h00);
    check("rst_config", cfg, 8'h0A);
    check("rst_gpio", gpio, 8'hFF);
    check("rst_alarm_en", alarm_en, 8'h00);
    check("rst_count_time", count_time, 8'h02);
    check("rst_sda_oe", bus.oSda_oe, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_alert_n", alert_n, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);

    // Single write
    s0 = strobe_cnt;
    reg_write(8'h00, 8'h4E, acks);
    check("wr_acks", acks, 3);
    check("wr_speed", speed, 8'h4E);
    check("wr_strobes", strobe_cnt - s0, 1);
    check("wr_addr", wr_addr, 8'h00);
    check("wr_state_idle", dbg_state, ST_IDLE);

    // Wrong address: never drives SDA, no register changes
    s0 = strobe_cnt;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h92, -1, aoe);
    write_byte(8'h00, -1, aoe);
    write_byte(8'h77, -1, aoe);
    i2c_stop();
    check("badaddr_oe", oe_seen, 1'b0);
    check("badaddr_speed", speed, 8'h4E);
    check("badaddr_strobes", strobe_cnt - s0, 0);

    // Repeated-start read of TACH0
    reg_read(8'h0C, rd, aoe);
    check("rd_tach0", rd, 8'h64);
    check("rd_ack_slot_oe", aoe, 1'b0);
    reg_read(8'h0E, rd, aoe);
    check("rd_tach1", rd, 8'h99);

    // Init sequence table
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      reg_write(vecs[i].addr, vecs[i].wdata, acks);
      check($sformatf("tbl_acks_%0d", i), acks, 3);
      check($sformatf("tbl_wr_addr_%0d", i), wr_addr, vecs[i].addr);
      if (i == 7) check("tbl_strobes", strobe_cnt - s0, 8);
      reg_read(vecs[i].addr, rd, aoe);
      check($sformatf("tbl_rd_%0d", i), rd, vecs[i].exp_rd);
    end
    check("init_speed", speed, 8'h4E);
    check("init_config", cfg, 8'h2A);
    check("init_gpio", gpio, 8'hF5);
    check("init_alarm_en", alarm_en, 8'h0F);
    check("init_count_time", count_time, 8'h02);

    // Status alarm, read-to-clear
    check("alert_idle", alert_n, 1'b1);
    alarm_set = 5'b00010;
    tick(1);
    alarm_set = 5'd0;
    tick(2);
    check("alert_set", alert_n, 1'b0);
    reg_read(8'h0A, rd, aoe);
    check("status_rd1", rd, 8'h02);
    check("alert_cleared", alert_n, 1'b1);
    reg_read(8'h0A, rd, aoe);
    check("status_rd2", rd, 8'h00);

    // STOP in mid-byte discards the partial data
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h90, -1, aoe);
    write_byte(8'h00, -1, aoe);
    write_bits(8'hA5, 4, -1);
    i2c_stop();
    check("stop_mid_speed", speed, 8'h4E);
    check("stop_mid_strobes", strobe_cnt - s0, 0);
    check("stop_mid_state", dbg_state, ST_IDLE);

    // Reset in the middle of a read byte (speed=0x4E, MSB 0 -> SDA driven low)
    i2c_start();
    write_byte(8'h90, -1, aoe);
    write_byte(8'h00, -1, aoe);
    i2c_start();
    write_byte(8'h91, -1, aoe);
    check("rd_msb_driven", bus.oSda_oe, 1'b1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_read_oe", bus.oSda_oe, 1'b0);
    rst = 1'b0;
    oe_seen = 1'b0;
    read_byte(1'b1, rd, aoe);
    i2c_stop();
    check("post_rst_oe", oe_seen, 1'b0);
    check("post_rst_speed", speed, 8'h00);

    // 1-cycle SCL glitch inside a data byte must not count as a bit
    i2c_start();
    write_byte(8'h90, -1, aoe);
    write_byte(8'h00, -1, aoe);
    write_byte(8'h4E, 3, aoe);
    check("glitch_ack", aoe, 1'b1);
    i2c_stop();
    check("glitch_speed", speed, 8'h4E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
